// File: rtl/bram72k_pkg.sv
// Shared widths and read-mode codes for the 72 Kbit dual-width block RAM.
package bram72k_pkg;
    localparam int DATA_W    = 72;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = 9;
    localparam int WIDE_W    = 144;

    localparam logic [3:0] RW_72  = 4'b0000;
    localparam logic [3:0] RW_144 = 4'b0010;

    // Only the exact double-word code selects 144-bit reads; every other code reads 72 bits.
    function automatic bit is_wide(input logic [3:0] read_width);
        return (read_width == RW_144);
    endfunction
endpackage

// File: rtl/bram72k_out_stage.sv
// 144-bit read-data register: sync active-low clear, load enable, upper half forced to zero in 72-bit mode.
// Latency 1 cycle; holds its value while i_ce is low.
module bram72k_out_stage
    import bram72k_pkg::*;
#(
    parameter bit WIDE = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_ce,
    input  logic [WIDE_W-1:0] i_dat,
    output logic [WIDE_W-1:0] o_dat
);
    localparam logic [WIDE_W-1:0] MASK = WIDE ? {WIDE_W{1'b1}} : {{DATA_W{1'b0}}, {DATA_W{1'b1}}};

    logic [WIDE_W-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dat <= '0;
        end else if (i_ce) begin
            r_dat <= i_dat & MASK;
        end
    end

    assign o_dat = r_dat;
endmodule

// File: rtl/bram72k_dual_width.sv
// 1024x72 block RAM, byte-lane writes, 72- or 144-bit (even/odd pair) read-first reads; latency 1, or 2 with BRAM72K_OUTREG_EN.
// No backpressure: rden gates the read register, outreg_ce gates the optional output register.
module bram72k_dual_width
    import bram72k_pkg::*;
#(
    parameter logic [3:0] READ_WIDTH = 4'b0010,
    parameter int         ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     din,
    input  logic [NUM_LANES-1:0]  we,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddrhi,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddrhi,
    input  logic                  outreg_ce,
    output logic [WIDE_W-1:0]     dout
);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam bit IS_WIDE = is_wide(READ_WIDTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Memory is never reset, so writes proceed regardless of reset_n.
    always_ff @(posedge clk) begin
        if (wren) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (we[l]) begin
                    r_mem[wraddrhi][l*BYTE_W +: BYTE_W] <= din[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic [ADDR_WIDTH-1:0] w_addr_even;
    logic [ADDR_WIDTH-1:0] w_addr_odd;
    logic [DATA_W-1:0]     w_rd_even;
    logic [DATA_W-1:0]     w_rd_odd;
    logic [DATA_W-1:0]     w_rd_single;
    logic [WIDE_W-1:0]     w_rd_dat;
    logic [WIDE_W-1:0]     w_stage1;

    assign w_addr_even = {rdaddrhi[ADDR_WIDTH-1:1], 1'b0};
    assign w_addr_odd  = {rdaddrhi[ADDR_WIDTH-1:1], 1'b1};
    assign w_rd_even   = r_mem[w_addr_even];
    assign w_rd_odd    = r_mem[w_addr_odd];
    assign w_rd_single = r_mem[rdaddrhi];
    // Upper half in 72-bit mode is masked off inside the output stage.
    assign w_rd_dat    = IS_WIDE ? {w_rd_odd, w_rd_even} : {w_rd_odd, w_rd_single};

    // Sampling pre-write array contents at the same edge as the write gives read-first behaviour.
    bram72k_out_stage #(.WIDE(IS_WIDE)) u_stage1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_ce    (rden),
        .i_dat   (w_rd_dat),
        .o_dat   (w_stage1)
    );

`ifdef BRAM72K_OUTREG_EN
    bram72k_out_stage #(.WIDE(IS_WIDE)) u_stage2 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_ce    (outreg_ce),
        .i_dat   (w_stage1),
        .o_dat   (dout)
    );
`else
    logic w_unused_outreg_ce;
    assign w_unused_outreg_ce = outreg_ce;
    assign dout = w_stage1;
`endif
endmodule

// File: tb/tb_bram72k_dual_width.sv
// Directed self-checking bench: a 144-bit and a 72-bit instance share all inputs.
module tb_bram72k_dual_width;
    localparam int AW = 10;
`ifdef BRAM72K_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [71:0]   din;
    logic [8:0]    we;
    logic          wren;
    logic [AW-1:0] wraddrhi;
    logic          rden;
    logic [AW-1:0] rdaddrhi;
    logic          outreg_ce;
    logic [143:0]  dout_w;
    logic [143:0]  dout_n;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [71:0] A4 = 72'h11_2233445566778899;
    localparam logic [71:0] A5 = 72'h0A_0102030405060708;
    localparam logic [71:0] A6 = 72'h5A_A5A5A5A55A5A5A5A;
    localparam logic [71:0] Z  = 72'h0;

    always #5 clk = ~clk;

    bram72k_dual_width #(.READ_WIDTH(4'b0010), .ADDR_WIDTH(AW)) u_wide (
        .clk(clk), .reset_n(reset_n), .din(din), .we(we), .wren(wren),
        .wraddrhi(wraddrhi), .rden(rden), .rdaddrhi(rdaddrhi),
        .outreg_ce(outreg_ce), .dout(dout_w)
    );

    bram72k_dual_width #(.READ_WIDTH(4'b0000), .ADDR_WIDTH(AW)) u_narrow (
        .clk(clk), .reset_n(reset_n), .din(din), .we(we), .wren(wren),
        .wraddrhi(wraddrhi), .rden(rden), .rdaddrhi(rdaddrhi),
        .outreg_ce(outreg_ce), .dout(dout_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [71:0] d, input logic [8:0] en);
        wraddrhi = a; din = d; we = en; wren = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rdaddrhi = a; rden = 1'b1;
        tick();
        rden = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    initial begin
        reset_n = 1'b0; rden = 1'b1; rdaddrhi = '0; outreg_ce = 1'b1;
        wren = 1'b1; we = 9'h1ff; wraddrhi = 4; din = A4;

        // Reset with rden high; writes issued during reset must still land.
        tick();
        check("rst0_w", dout_w, '0);
        check("rst0_n", dout_n, '0);
        wraddrhi = 5; din = A5;
        tick();
        check("rst1_w", dout_w, '0);
        check("rst1_n", dout_n, '0);
        wren = 1'b0;
        tick();
        check("rst2_w", dout_w, '0);
        check("rst2_n", dout_n, '0);
        reset_n = 1'b1;
        rden = 1'b0;

        do_read(5);
        check("pair5_w", dout_w, {A5, A4});
        check("pair5_n", dout_n, {Z, A5});
        do_read(4);
        check("pair4_w", dout_w, {A5, A4});
        check("pair4_n", dout_n, {Z, A4});

        do_write(6, A6, 9'h1ff);
        do_write(7, 72'hFF_FFFFFFFFFFFFFFFF, 9'h1ff);
        do_write(7, Z, 9'h003);
        do_read(7);
        check("lane_lo_n", dout_n, {Z, 72'hFF_FFFFFFFFFFFF0000});
        check("lane_lo_w", dout_w, {72'hFF_FFFFFFFFFFFF0000, A6});
        do_write(7, Z, 9'h100);
        do_write(7, 72'h12_3456789ABCDEF012, 9'h000);
        do_read(7);
        check("lane_hi_n", dout_n, {Z, 72'h00_FFFFFFFFFFFF0000});

        // Read-first collision on address 2.
        do_write(2, 72'h1, 9'h1ff);
        do_write(3, 72'h3, 9'h1ff);
        wraddrhi = 2; din = 72'h2; we = 9'h1ff; wren = 1'b1;
        rdaddrhi = 2; rden = 1'b1;
        tick();
        wren = 1'b0; rden = 1'b0;
        repeat (LAT - 1) tick();
        check("rdw_old_n", dout_n, {Z, 72'h1});
        check("rdw_old_w", dout_w, {72'h3, 72'h1});
        do_read(2);
        check("rdw_new_n", dout_n, {Z, 72'h2});
        check("rdw_new_w", dout_w, {72'h3, 72'h2});

        // rden low holds dout while the source word is overwritten.
        do_read(4);
        check("hold0_w", dout_w, {A5, A4});
        for (int i = 0; i < 5; i++) begin
            wraddrhi = 4; din = 72'(i + 100); we = 9'h1ff; wren = 1'b1;
            tick();
            check("hold_w", dout_w, {A5, A4});
            check("hold_n", dout_n, {Z, A4});
        end
        wren = 1'b0;
        do_write(4, A4, 9'h1ff);

        // Mid-stream reset clears output only.
        do_read(5);
        reset_n = 1'b0; rden = 1'b1; rdaddrhi = 5;
        tick();
        check("midrst_w", dout_w, '0);
        check("midrst_n", dout_n, '0);
        reset_n = 1'b1; rden = 1'b0;
        repeat (LAT) tick();
        check("midrst_keep", dout_w, '0);

`ifdef BRAM72K_OUTREG_EN
        rdaddrhi = 4; rden = 1'b1;
        tick();
        rden = 1'b0;
        check("or_lat1", dout_w, '0);
        tick();
        check("or_lat2", dout_w, {A5, A4});
        outreg_ce = 1'b0;
        rdaddrhi = 2; rden = 1'b1;
        tick();
        rden = 1'b0;
        tick();
        tick();
        check("or_ce_hold", dout_w, {A5, A4});
        outreg_ce = 1'b1;
        tick();
        check("or_ce_load", dout_w, {72'h3, 72'h2});
        reset_n = 1'b0;
        tick();
        check("or_rst", dout_w, '0);
        reset_n = 1'b1;
        tick();
        check("or_rst_s1", dout_w, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
